ddr_frame_arbiter: RTL and testbench
====================================

// Module: ddr_frame_arbiter
// PURPOSE
//  Shares the single DDR2 controller port between the VGA capture write stream
//  (vga_seq_fifo drain) and the FRC read stream (seq_frc_fifo fill). Issues one
//  burst command at a time, picks read/write with bounded starvation, and runs
//  triple-buffer frame rotation with image_hold/write_hold freeze controls.
// PARAMETERS
//  ADDR_W       31        DDR command address width (words)
//  FRAME_WORDS  491520    frame size in DDR words; multiple of BURST_LEN
//  BURST_LEN    4         DDR words per command (address increment)
//  RD_STREAK    8         max consecutive read grants while wr_req pending
// PORTS
//  clk           in   1       controller clock (DDR user clock)
//  rst           in   1       async active-high reset
//  phy_init_done in   1       DDR PHY calibrated; no commands before
//  wr_req        in   1       VGA FIFO holds >= one burst (not prog_empty)
//  rd_req        in   1       FRC FIFO has room for one burst (not prog_full)
//  vga_vsync     in   1       capture frame start, level, clk-synchronous
//  lcdc_vsync    in   1       display frame start, level, clk-synchronous
//  image_hold    in   1       freeze read buffer
//  write_hold    in   1       suppress all writes and write rotation
//  cmd_ready     in   1       controller accepts command (af not full)
//  burst_done    in   1       1-cycle pulse: granted burst data fully moved
//  cmd_valid     out  1       command valid, held until cmd_ready
//  cmd_rnw       out  1       1 = read, 0 = write
//  cmd_addr      out  ADDR_W  burst word address
//  wr_grant      out  1       write burst in flight (gates VGA FIFO rd_en/wdf_wren)
//  rd_grant      out  1       read burst in flight (gates FRC FIFO wr_en)
//  wr_buf        out  2       current write buffer index 0..2
//  rd_buf        out  2       current read buffer index 0..2
//  reach_end     out  1       1-cycle pulse when write offset wraps frame end
// BEHAVIOUR
//  Reset: cmd_valid=0, cmd_rnw=0, cmd_addr=0, grants=0, reach_end=0,
//   wr_buf=0, rd_buf=1, done_buf=1, wr_off=rd_off=0, streak=0, state=INIT.
//  Vsyncs: rising-edge detected (registered prev); edge sets pending flag,
//   applied only in ARB (never mid-burst); a second edge before apply is merged.
//  FSM: INIT -> ARB when phy_init_done. ARB: apply pending vsyncs, then:
//   eligible_rd = rd_req; eligible_wr = wr_req & ~write_hold.
//   both eligible: read unless streak==RD_STREAK -> write. One eligible: it.
//   none: stay ARB. Grant -> CMD next cycle with cmd_valid=1,
//   cmd_addr = buf*FRAME_WORDS + off, grant flag set.
//  CMD: hold cmd_valid/addr/rnw stable until cmd_ready; then cmd_valid=0,
//   -> BURST. BURST: wait burst_done -> off += BURST_LEN; -> ARB, grant=0.
//   Read grant: streak+1 (saturating RD_STREAK) if wr_req, else 0; write: streak=0.
//  Offsets wrap: off+BURST_LEN==FRAME_WORDS -> off=0; write wrap pulses reach_end.
//  Latency ARB decision -> cmd_valid: 1 cycle; burst_done -> next cmd_valid: 2.
//  vga vsync apply: wr_off=0; if ~write_hold: done_buf=wr_buf, wr_buf= index
//   not in {wr_buf, rd_buf}. lcdc vsync apply: rd_off=0; if ~image_hold:
//   rd_buf=done_buf. Both pending same cycle: write rotation first, then read.
//   Invariant wr_buf != rd_buf always holds; no index ever 3.
//  write_hold asserted mid-burst: current burst completes; no new writes.
//  rst mid-burst: immediate return to reset state, command dropped.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs stat_rd_bursts[31:0], stat_wr_bursts[31:0]
//   (count burst_done per direction, wrap at 2^32, reset 0) and
//   stat_rd_starve (sticky: rd_req high >1024 consecutive cycles w/o grant,
//   cleared only by rst). Undefined: ports and logic absent; behaviour
//   otherwise identical.
// TESTING
//  1 rst, phy_init_done=0, rd_req=wr_req=1 -> no cmd_valid; init=1 -> read cmd
//    addr 1*FRAME_WORDS after 1 ARB cycle.
//  2 rd_req, wr_req held 1, cmd_ready=1, burst_done 3 cycles after cmd -> pattern
//    8 reads, 1 write, repeating; write addrs 0,4,8...
//  3 cmd_ready low 5 cycles -> cmd_valid/addr/rnw stable all 5, one accept only.
//  4 vga_vsync edge x3, no lcdc_vsync -> wr_buf 0->2->0->2, rd_buf stays 1;
//    then lcdc_vsync -> rd_buf=0 (last done), wr_buf!=rd_buf throughout.
//  5 both vsyncs same cycle from reset -> wr_buf=2, rd_buf=0, offsets 0;
//    image_hold=1 repeat -> rd_buf unchanged; write_hold=1 -> no writes granted.
//  6 write FRAME_WORDS/BURST_LEN bursts -> reach_end pulse once, next addr=base;
//    rst mid-BURST -> all outputs reset values same cycle.

Source files
------------

// File: rtl/ddr_frame_arbiter.sv
// ddr_frame_arbiter
// Purpose     : shares the single DDR2 command port between the VGA capture write
//               stream and the FRC read stream, and rotates triple frame buffers.
// Latency     : ARB decision -> cmd_valid 1 cycle; burst_done -> next cmd_valid 2 cycles.
// Backpressure: cmd_valid/cmd_addr/cmd_rnw hold until cmd_ready; one burst in flight.
// Ports:
//   clk, rst                 controller clock, async active-high reset
//   phy_init_done            no command is issued before DDR calibration completes
//   wr_req / rd_req          VGA FIFO holds a burst / FRC FIFO has room for a burst
//   vga_vsync / lcdc_vsync   frame starts (rising edge), applied between bursts
//   image_hold / write_hold  freeze read buffer / suppress writes and write rotation
//   cmd_ready, burst_done    controller command accept, burst data fully moved
//   cmd_valid/rnw/addr       burst command to the controller
//   wr_grant / rd_grant      direction of the burst in flight (FIFO enables)
//   wr_buf / rd_buf          current buffer indices 0..2
//   reach_end                1-cycle pulse when the write offset wraps the frame
// Option: `define ARB_STATS_EN adds stat_rd_bursts, stat_wr_bursts, stat_rd_starve.
module ddr_frame_arbiter #(
  parameter int ADDR_W      = 31,
  parameter int FRAME_WORDS = 491520,
  parameter int BURST_LEN   = 4,
  parameter int RD_STREAK   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              phy_init_done,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              vga_vsync,
  input  logic              lcdc_vsync,
  input  logic              image_hold,
  input  logic              write_hold,
  input  logic              cmd_ready,
  input  logic              burst_done,
  output logic              cmd_valid,
  output logic              cmd_rnw,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              wr_grant,
  output logic              rd_grant,
  output logic [1:0]        wr_buf,
  output logic [1:0]        rd_buf,
  output logic              reach_end
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_rd_bursts,
  output logic [31:0]       stat_wr_bursts,
  output logic              stat_rd_starve
`endif
);

  localparam int                ST_W   = $clog2(RD_STREAK + 1);
  localparam logic [ADDR_W-1:0] FW     = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BL     = ADDR_W'(BURST_LEN);
  localparam logic [ST_W-1:0]   ST_MAX = ST_W'(RD_STREAK);

  typedef enum logic [1:0] {S_INIT, S_ARB, S_CMD, S_BURST} state_t;

  state_t            state, state_nxt;
  logic              pick_rd, pick_wr;
  logic              elig_rd, elig_wr;
  logic [ST_W-1:0]   streak;
  logic [1:0]        done_buf;
  logic [ADDR_W-1:0] wr_off, rd_off;

  logic              vga_prev, lcdc_prev, vga_pend, lcdc_pend;
  logic              vga_edge, lcdc_edge, vga_apply, lcdc_apply;

  // Post-rotation view of buffers/offsets, used both for the next state and for
  // the address of a command granted in the same ARB cycle.
  logic [1:0]        wr_buf_a, rd_buf_a, done_buf_a;
  logic [ADDR_W-1:0] wr_off_a, rd_off_a;

  function automatic logic [ADDR_W-1:0] buf_base(input logic [1:0] idx);
    logic [ADDR_W-1:0] b;
    case (idx)
      2'd1:    b = FW;
      2'd2:    b = FW + FW;
      default: b = '0;
    endcase
    return b;
  endfunction

  // Index in 0..2 not used by either argument.
  function automatic logic [1:0] free_idx(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    if (a != 2'd0 && b != 2'd0)      r = 2'd0;
    else if (a != 2'd1 && b != 2'd1) r = 2'd1;
    else                             r = 2'd2;
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] off_inc(input logic [ADDR_W-1:0] o);
    logic [ADDR_W-1:0] n;
    n = o + BL;
    if (n == FW) n = '0;
    return n;
  endfunction

  assign elig_rd    = rd_req;
  assign elig_wr    = wr_req & ~write_hold;
  assign vga_edge   = vga_vsync & ~vga_prev;
  assign lcdc_edge  = lcdc_vsync & ~lcdc_prev;
  // Vsyncs only take effect between bursts so a burst never straddles a rotation.
  assign vga_apply  = (state == S_ARB) & vga_pend;
  assign lcdc_apply = (state == S_ARB) & lcdc_pend;

  // Write rotation first, so a simultaneous read rotation picks up the frame just
  // completed. done_buf always differs from wr_buf, which keeps wr_buf != rd_buf.
  always_comb begin
    wr_buf_a   = wr_buf;
    rd_buf_a   = rd_buf;
    done_buf_a = done_buf;
    wr_off_a   = wr_off;
    rd_off_a   = rd_off;
    if (vga_apply) begin
      wr_off_a = '0;
      if (!write_hold) begin
        done_buf_a = wr_buf;
        wr_buf_a   = free_idx(wr_buf, rd_buf);
      end
    end
    if (lcdc_apply) begin
      rd_off_a = '0;
      if (!image_hold) rd_buf_a = done_buf_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pick_rd   = 1'b0;
    pick_wr   = 1'b0;
    case (state)
      S_INIT: if (phy_init_done) state_nxt = S_ARB;
      S_ARB: begin
        // Reads win ties until RD_STREAK consecutive reads starved a pending write.
        if (elig_rd && elig_wr) begin
          if (streak == ST_MAX) pick_wr = 1'b1;
          else                  pick_rd = 1'b1;
        end else begin
          pick_rd = elig_rd;
          pick_wr = elig_wr;
        end
        if (pick_rd || pick_wr) state_nxt = S_CMD;
      end
      S_CMD:   if (cmd_ready)  state_nxt = S_BURST;
      S_BURST: if (burst_done) state_nxt = S_ARB;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_rnw   <= 1'b0;
      cmd_addr  <= '0;
      wr_grant  <= 1'b0;
      rd_grant  <= 1'b0;
      reach_end <= 1'b0;
      wr_buf    <= 2'd0;
      rd_buf    <= 2'd1;
      done_buf  <= 2'd1;
      wr_off    <= '0;
      rd_off    <= '0;
      streak    <= '0;
      vga_prev  <= 1'b0;
      lcdc_prev <= 1'b0;
      vga_pend  <= 1'b0;
      lcdc_pend <= 1'b0;
    end else begin
      vga_prev  <= vga_vsync;
      lcdc_prev <= lcdc_vsync;
      // A new edge wins over clearing so an edge landing on the apply cycle is kept.
      vga_pend  <= vga_edge  | (vga_pend  & ~vga_apply);
      lcdc_pend <= lcdc_edge | (lcdc_pend & ~lcdc_apply);
      wr_buf    <= wr_buf_a;
      rd_buf    <= rd_buf_a;
      done_buf  <= done_buf_a;
      wr_off    <= wr_off_a;
      rd_off    <= rd_off_a;
      reach_end <= 1'b0;

      if (pick_rd || pick_wr) begin
        cmd_valid <= 1'b1;
        cmd_rnw   <= pick_rd;
        cmd_addr  <= pick_rd ? buf_base(rd_buf_a) + rd_off_a
                             : buf_base(wr_buf_a) + wr_off_a;
        rd_grant  <= pick_rd;
        wr_grant  <= pick_wr;
        if (pick_wr || !wr_req)  streak <= '0;
        else if (streak != ST_MAX) streak <= streak + 1'b1;
      end

      if (state == S_CMD && cmd_ready) cmd_valid <= 1'b0;

      if (state == S_BURST && burst_done) begin
        rd_grant <= 1'b0;
        wr_grant <= 1'b0;
        if (rd_grant) rd_off <= off_inc(rd_off);
        if (wr_grant) begin
          wr_off <= off_inc(wr_off);
          if (off_inc(wr_off) == '0) reach_end <= 1'b1;
        end
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [10:0] starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_bursts <= '0;
      stat_wr_bursts <= '0;
      stat_rd_starve <= 1'b0;
      starve_cnt     <= '0;
    end else begin
      if (state == S_BURST && burst_done) begin
        if (rd_grant) stat_rd_bursts <= stat_rd_bursts + 32'd1;
        if (wr_grant) stat_wr_bursts <= stat_wr_bursts + 32'd1;
      end
      // Sticky flag once rd_req has waited more than 1024 cycles without service.
      if (!rd_req || pick_rd || rd_grant) starve_cnt <= '0;
      else if (starve_cnt != 11'd1024)    starve_cnt <= starve_cnt + 11'd1;
      else                                stat_rd_starve <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
module tb_ddr_frame_arbiter;

  logic        clk;
  logic        rst;
  logic        phy_init_done;
  logic        wr_req, rd_req;
  logic        vga_vsync, lcdc_vsync;
  logic        image_hold, write_hold;
  logic        cmd_ready, burst_done;
  logic        cmd_valid, cmd_rnw;
  logic [30:0] cmd_addr;
  logic        wr_grant, rd_grant;
  logic [1:0]  wr_buf, rd_buf;
  logic        reach_end;

  int checks = 0;
  int errors = 0;

  // Small frame (32 words = 8 bursts) so frame wrap is reachable quickly.
  ddr_frame_arbiter #(
    .ADDR_W(31), .FRAME_WORDS(32), .BURST_LEN(4), .RD_STREAK(8)
  ) dut (
    .clk(clk), .rst(rst), .phy_init_done(phy_init_done),
    .wr_req(wr_req), .rd_req(rd_req),
    .vga_vsync(vga_vsync), .lcdc_vsync(lcdc_vsync),
    .image_hold(image_hold), .write_hold(write_hold),
    .cmd_ready(cmd_ready), .burst_done(burst_done),
    .cmd_valid(cmd_valid), .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr),
    .wr_grant(wr_grant), .rd_grant(rd_grant),
    .wr_buf(wr_buf), .rd_buf(rd_buf), .reach_end(reach_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd(input string tag);
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, 32'(cmd_valid), 32'd1);
  endtask

  // Expects a command, accepts it (cmd_ready must be 1), completes the burst and
  // returns on the first ARB cycle afterwards.
  task automatic run_burst(input logic e_rnw, input logic [30:0] e_addr, input string tag);
    wait_cmd(tag);
    chk({tag, "_rnw"},  32'(cmd_rnw),  32'(e_rnw));
    chk({tag, "_addr"}, 32'(cmd_addr), 32'(e_addr));
    tick();
    chk({tag, "_grant"}, 32'(e_rnw ? rd_grant : wr_grant), 32'd1);
    tick();
    tick();
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
  endtask

  task automatic pulse(input logic v, input logic l);
    vga_vsync  = v;
    lcdc_vsync = l;
    tick();
    vga_vsync  = 1'b0;
    lcdc_vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    phy_init_done = 1'b0;
    rd_req = 1'b0; wr_req = 1'b0;
    vga_vsync = 1'b0; lcdc_vsync = 1'b0;
    image_hold = 1'b0; write_hold = 1'b0;
    cmd_ready = 1'b1; burst_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    phy_init_done = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    phy_init_done = 1'b0;
    rd_req = 1'b1; wr_req = 1'b1;
    vga_vsync = 1'b0; lcdc_vsync = 1'b0;
    image_hold = 1'b0; write_hold = 1'b0;
    cmd_ready = 1'b1; burst_done = 1'b0;
    tick();
    tick();

    // 1: reset values, no command before calibration, first read at base of buffer 1
    chk("rst_vld",    32'(cmd_valid), 32'd0);
    chk("rst_rnw",    32'(cmd_rnw),   32'd0);
    chk("rst_addr",   32'(cmd_addr),  32'd0);
    chk("rst_wgnt",   32'(wr_grant),  32'd0);
    chk("rst_rgnt",   32'(rd_grant),  32'd0);
    chk("rst_wbuf",   32'(wr_buf),    32'd0);
    chk("rst_rbuf",   32'(rd_buf),    32'd1);
    chk("rst_reach",  32'(reach_end), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_noinit_vld", 32'(cmd_valid), 32'd0);
    end
    phy_init_done = 1'b1;
    tick();
    chk("t1_arb_vld", 32'(cmd_valid), 32'd0);
    tick();
    chk("t1_cmd_vld",  32'(cmd_valid), 32'd1);
    chk("t1_cmd_rnw",  32'(cmd_rnw),   32'd1);
    chk("t1_cmd_addr", 32'(cmd_addr),  32'd32);

    // 2: both requesting -> 8 reads then 1 write, twice
    for (int i = 0; i < 18; i++) begin
      if (i % 9 == 8) run_burst(1'b0, 31'(4 * (i / 9)), "t2_wr");
      else            run_burst(1'b1, 31'(32 + 4 * (i % 9)), "t2_rd");
      if (i < 17) begin
        chk("t2_lat_gap", 32'(cmd_valid), 32'd0);
        tick();
        chk("t2_lat_cmd", 32'(cmd_valid), 32'd1);
      end
    end

    // 3: cmd_ready low for 5 cycles -> command held stable, accepted once
    cmd_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_vld",  32'(cmd_valid), 32'd1);
      chk("t3_hold_addr", 32'(cmd_addr),  32'd32);
      chk("t3_hold_rnw",  32'(cmd_rnw),   32'd1);
      if (i < 4) tick();
    end
    cmd_ready = 1'b1;
    tick();
    chk("t3_accept_vld", 32'(cmd_valid), 32'd0);
    chk("t3_accept_gnt", 32'(rd_grant),  32'd1);
    tick();
    tick();
    chk("t3_single_vld", 32'(cmd_valid), 32'd0);
    burst_done = 1'b1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    tick();
    burst_done = 1'b0;
    tick();

    // 4: three capture vsyncs, then one display vsync
    do_reset();
    wr_req = 1'b1;
    run_burst(1'b0, 31'd0, "t4_w0");
    wr_req = 1'b0;
    pulse(1'b1, 1'b0);
    chk("t4_v1_wbuf", 32'(wr_buf), 32'd2);
    chk("t4_v1_rbuf", 32'(rd_buf), 32'd1);
    pulse(1'b1, 1'b0);
    chk("t4_v2_wbuf", 32'(wr_buf), 32'd0);
    chk("t4_v2_rbuf", 32'(rd_buf), 32'd1);
    pulse(1'b1, 1'b0);
    chk("t4_v3_wbuf", 32'(wr_buf), 32'd2);
    chk("t4_v3_rbuf", 32'(rd_buf), 32'd1);
    pulse(1'b0, 1'b1);
    chk("t4_l_wbuf", 32'(wr_buf), 32'd2);
    chk("t4_l_rbuf", 32'(rd_buf), 32'd0);
    wr_req = 1'b1;
    run_burst(1'b0, 31'd64, "t4_wnew");
    wr_req = 1'b0;
    rd_req = 1'b1;
    run_burst(1'b1, 31'd0, "t4_rnew");
    rd_req = 1'b0;

    // 5: simultaneous vsyncs, image_hold, write_hold
    do_reset();
    pulse(1'b1, 1'b1);
    chk("t5_both_wbuf", 32'(wr_buf), 32'd2);
    chk("t5_both_rbuf", 32'(rd_buf), 32'd0);
    wr_req = 1'b1;
    run_burst(1'b0, 31'd64, "t5_w");
    wr_req = 1'b0;
    image_hold = 1'b1;
    pulse(1'b1, 1'b1);
    image_hold = 1'b0;
    chk("t5_ih_wbuf", 32'(wr_buf), 32'd1);
    chk("t5_ih_rbuf", 32'(rd_buf), 32'd0);
    write_hold = 1'b1;
    pulse(1'b1, 1'b0);
    chk("t5_wh_wbuf", 32'(wr_buf), 32'd1);
    chk("t5_wh_rbuf", 32'(rd_buf), 32'd0);
    wr_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5_wh_novld", 32'(cmd_valid), 32'd0);
      chk("t5_wh_nognt", 32'(wr_grant),  32'd0);
    end
    write_hold = 1'b0;
    wait_cmd("t5_mid");
    chk("t5_mid_rnw",  32'(cmd_rnw),  32'd0);
    chk("t5_mid_addr", 32'(cmd_addr), 32'd32);
    tick();
    write_hold = 1'b1;
    tick();
    chk("t5_mid_gnt", 32'(wr_grant), 32'd1);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("t5_mid_done", 32'(wr_grant), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_mid_novld", 32'(cmd_valid), 32'd0);
    end
    wr_req = 1'b0;
    write_hold = 1'b0;

    // 6: full frame of writes -> one reach_end pulse, wrap to base; reset mid-burst
    do_reset();
    wr_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_burst(1'b0, 31'(4 * i), "t6_w");
      chk("t6_reach", 32'(reach_end), (i == 7) ? 32'd1 : 32'd0);
    end
    tick();
    chk("t6_reach_clr", 32'(reach_end), 32'd0);
    chk("t6_wrap_vld",  32'(cmd_valid), 32'd1);
    chk("t6_wrap_addr", 32'(cmd_addr),  32'd0);
    run_burst(1'b0, 31'd0, "t6_base");
    chk("t6_base_reach", 32'(reach_end), 32'd0);
    wr_req = 1'b0;
    pulse(1'b1, 1'b0);
    chk("t6_pre_wbuf", 32'(wr_buf), 32'd2);
    rd_req = 1'b1;
    wait_cmd("t6_rd");
    chk("t6_rd_addr", 32'(cmd_addr), 32'd32);
    tick();
    chk("t6_rd_gnt", 32'(rd_grant), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_vld",   32'(cmd_valid), 32'd0);
    chk("t6_rst_rnw",   32'(cmd_rnw),   32'd0);
    chk("t6_rst_addr",  32'(cmd_addr),  32'd0);
    chk("t6_rst_rgnt",  32'(rd_grant),  32'd0);
    chk("t6_rst_wgnt",  32'(wr_grant),  32'd0);
    chk("t6_rst_wbuf",  32'(wr_buf),    32'd0);
    chk("t6_rst_rbuf",  32'(rd_buf),    32'd1);
    chk("t6_rst_reach", 32'(reach_end), 32'd0);
    rd_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
